mmp_iddmm_var: RTL and testbench

- Word-serial Montgomery modular multiplier (CIOS form): res = x*y*R^-1 mod m, with R = 2^(K*len).
- Operand length `len` is selected per task at runtime, from 1 to N words. This generalises the fixed-group IDDMM top.
- Sits in the RSA subsystem next to the exponentiation controller. Operands are loaded word-wise into internal RAMs; the result is read back from a result RAM.

---
 rtl/mmp_iddmm_var.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mmp_iddmm_var.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmp_iddmm_var.sv
// Word-serial Montgomery modular multiplier (CIOS): res = x*y*R^-1 mod m, R = 2^(K*len).
// The operand length len (1..N words) is chosen per task.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_ena/addr/data    word writes into the x (bit0), y (bit1) and m (bit2) RAMs; ignored while busy
//   m1                  -m^-1 mod 2^K, latched on grant
//   len                 operand length in words, latched on grant
//   task_req            start request
//   task_grant          1-cycle pulse: request accepted
//   task_err            1-cycle pulse: request rejected (len == 0 or len > N)
//   busy                high from the grant cycle through the task_end cycle
//   task_end            1-cycle pulse: result RAM holds the result
//   rd_addr / rd_data   result RAM read port, 1-cycle registered latency
//
// Optional feature macro MMP_IDDMM_RES_STREAM_EN adds res_valid/res_data, which stream the
// result words low word first, starting in the task_end cycle. busy is held until the last word.

module mmp_iddmm_var #(
  parameter int unsigned K      = 16,
  parameter int unsigned N      = 8,
  parameter int unsigned ADDR_W = $clog2(N),
  parameter int unsigned LEN_W  = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [K-1:0]      wr_data,
  input  logic [K-1:0]      m1,
  input  logic [LEN_W-1:0]  len,
  input  logic              task_req,
  output logic              task_grant,
  output logic              task_err,
  output logic              busy,
  output logic              task_end,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [K-1:0]      rd_data
`ifdef MMP_IDDMM_RES_STREAM_EN
  ,
  output logic              res_valid,
  output logic [K-1:0]      res_data
`endif
);

  localparam int unsigned TW = $clog2(N + 2);
  localparam int unsigned SW = 2 * K + 1;

  // StInit is the grant cycle; the accumulator is cleared on the accept edge.
  typedef enum logic [2:0] {
    StIdle, StInit, StLoopA, StLoopQ, StLoopB, StFinal, StDone, StStream
  } state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   len_q, i_q, j_q;
  logic [K-1:0]       m1_q, q_q;
  logic [K:0]         c_q;
  logic               borrow_q;
  logic               grant_q, err_q, busy_q, end_q;
  logic [K-1:0]       rd_data_q;

  logic [K-1:0]       x_ram   [N];
  logic [K-1:0]       y_ram   [N];
  logic [K-1:0]       m_ram   [N];
  logic [K-1:0]       res_ram [N];
  logic [K-1:0]       t_q     [N + 2];

`ifdef MMP_IDDMM_RES_STREAM_EN
  logic               sv_q;
  logic [K-1:0]       sd_q;
`endif

  // Datapath signals
  logic               legal, accept, last, use_t;
  logic [TW-1:0]      tj_idx, tl_idx, tl1_idx;
  logic [ADDR_W-1:0]  j_a;
  logic [K-1:0]       x_w, y_w, m_w, t_j, t_len, t_len1;
  logic [K-1:0]       mul_a, mul_b;
  logic [2*K-1:0]     prod, qprod;
  logic [SW-1:0]      acc;
  logic [K:0]         diff;
  logic [LEN_W-1:0]   i_nx;

  always_comb begin
    legal   = (len != '0) && (32'(len) <= N);
    accept  = (state_q == StIdle) && !busy_q && task_req && legal;
    last    = (j_q == len_q);
    tj_idx  = TW'(j_q);
    tl_idx  = TW'(len_q);
    tl1_idx = TW'(len_q) + TW'(1);
    j_a     = j_q[ADDR_W-1:0];
    x_w     = x_ram[j_a];
    y_w     = y_ram[i_q[ADDR_W-1:0]];
    m_w     = m_ram[j_a];
    t_j     = t_q[tj_idx];
    t_len   = t_q[tl_idx];
    t_len1  = t_q[tl1_idx];
    mul_a   = (state_q == StLoopB) ? q_q : x_w;
    mul_b   = (state_q == StLoopB) ? m_w : y_w;
    prod    = {{K{1'b0}}, mul_a} * {{K{1'b0}}, mul_b};
    qprod   = {{K{1'b0}}, t_q[0]} * {{K{1'b0}}, m1_q};
    // The j == len step of both loops only folds the carry into the top word.
    acc     = SW'(t_j) + SW'(c_q) + (last ? '0 : SW'(prod));
    diff    = {1'b0, t_j} - {1'b0, m_w} - {{K{1'b0}}, borrow_q};
    // Keep t unless it overflowed into t_len or t - m did not underflow.
    use_t   = (t_len != K'(1)) && borrow_q;
    i_nx    = i_q + LEN_W'(1);
  end

  // RAMs and accumulator: not reset.
  always_ff @(posedge clk) begin
    if (!busy_q) begin
      if (wr_ena[0]) x_ram[wr_addr] <= wr_data;
      if (wr_ena[1]) y_ram[wr_addr] <= wr_data;
      if (wr_ena[2]) m_ram[wr_addr] <= wr_data;
    end
    if (accept) begin
      for (int k = 0; k < int'(N) + 2; k++) t_q[TW'(k)] <= '0;
    end
    if (state_q == StLoopA) begin
      t_q[tj_idx] <= acc[K-1:0];
      if (last) t_q[tl1_idx] <= K'(acc[K]);
    end
    if (state_q == StLoopB) begin
      if (j_q != '0) t_q[tj_idx - TW'(1)] <= acc[K-1:0];
      if (last) t_q[tl_idx] <= t_len1 + K'(acc[K]);
    end
    if (state_q == StFinal) res_ram[j_a] <= diff[K-1:0];
    // Single-cycle rewrite of the result RAM from the t shadow copy.
    if (state_q == StDone && use_t) begin
      for (int k = 0; k < int'(N); k++) begin
        if (k < int'(len_q)) res_ram[ADDR_W'(k)] <= t_q[TW'(k)];
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      m1_q      <= '0;
      q_q       <= '0;
      c_q       <= '0;
      borrow_q  <= 1'b0;
      grant_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      rd_data_q <= '0;
`ifdef MMP_IDDMM_RES_STREAM_EN
      sv_q      <= 1'b0;
      sd_q      <= '0;
`endif
    end else begin
      grant_q   <= 1'b0;
      err_q     <= 1'b0;
      end_q     <= 1'b0;
      rd_data_q <= res_ram[rd_addr];
`ifdef MMP_IDDMM_RES_STREAM_EN
      sv_q      <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          // busy covers the task_end / last stream cycle; drop it before accepting again.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (task_req) begin
            if (legal) begin
              len_q   <= len;
              m1_q    <= m1;
              i_q     <= '0;
              grant_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StInit;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StInit: begin
          j_q     <= '0;
          c_q     <= '0;
          state_q <= StLoopA;
        end
        StLoopA: begin
          if (last) begin
            j_q     <= '0;
            c_q     <= '0;
            state_q <= StLoopQ;
          end else begin
            j_q <= j_q + LEN_W'(1);
            c_q <= acc[SW-1:K];
          end
        end
        StLoopQ: begin
          q_q     <= qprod[K-1:0];
          j_q     <= '0;
          c_q     <= '0;
          state_q <= StLoopB;
        end
        StLoopB: begin
          if (last) begin
            j_q      <= '0;
            c_q      <= '0;
            i_q      <= i_nx;
            borrow_q <= 1'b0;
            state_q  <= (i_nx < len_q) ? StLoopA : StFinal;
          end else begin
            j_q <= j_q + LEN_W'(1);
            c_q <= acc[SW-1:K];
          end
        end
        StFinal: begin
          borrow_q <= diff[K];
          if (j_q == len_q - LEN_W'(1)) begin
            j_q     <= '0;
            state_q <= StDone;
          end else begin
            j_q <= j_q + LEN_W'(1);
          end
        end
        StDone: begin
          end_q   <= 1'b1;
          state_q <= StIdle;
`ifdef MMP_IDDMM_RES_STREAM_EN
          sv_q <= 1'b1;
          sd_q <= use_t ? t_q[0] : res_ram[0];
          if (len_q > LEN_W'(1)) begin
            j_q     <= LEN_W'(1);
            state_q <= StStream;
          end
`endif
        end
        StStream: begin
`ifdef MMP_IDDMM_RES_STREAM_EN
          sv_q <= 1'b1;
          sd_q <= res_ram[j_a];
`endif
          if (j_q == len_q - LEN_W'(1)) begin
            j_q     <= '0;
            state_q <= StIdle;
          end else begin
            j_q <= j_q + LEN_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign task_grant = grant_q;
  assign task_err   = err_q;
  assign busy       = busy_q;
  assign task_end   = end_q;
  assign rd_data    = rd_data_q;
`ifdef MMP_IDDMM_RES_STREAM_EN
  assign res_valid  = sv_q;
  assign res_data   = sd_q;
`endif

endmodule

// File: tb/tb_mmp_iddmm_var.sv
module tb_mmp_iddmm_var;
  localparam int K  = 16;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    wr_ena = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [K-1:0]  wr_data = '0;
  logic [K-1:0]  m1 = '0;
  logic [LW-1:0] len = '0;
  logic          task_req = 1'b0;
  logic          task_grant, task_err, busy, task_end;
  logic [AW-1:0] rd_addr = '0;
  logic [K-1:0]  rd_data;
`ifdef MMP_IDDMM_RES_STREAM_EN
  logic          res_valid;
  logic [K-1:0]  res_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  mmp_iddmm_var #(.K(K), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .m1         (m1),
    .len        (len),
    .task_req   (task_req),
    .task_grant (task_grant),
    .task_err   (task_err),
    .busy       (busy),
    .task_end   (task_end),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
`ifdef MMP_IDDMM_RES_STREAM_EN
    ,
    .res_valid  (res_valid),
    .res_data   (res_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: x*y mod m, then divide by 2 modulo m once per bit of R.
  function automatic logic [63:0] mont_ref(input logic [63:0] x, input logic [63:0] y,
                                           input logic [63:0] m, input int l);
    logic [127:0] v;
    v = (128'(x) * 128'(y)) % 128'(m);
    for (int b = 0; b < K * l; b++) v = v[0] ? (v + 128'(m)) >> 1 : v >> 1;
    return v[63:0];
  endfunction

  // -m0^-1 mod 2^16 by Newton iteration.
  function automatic logic [15:0] neg_inv(input logic [15:0] m0);
    logic [15:0] r;
    r = m0;
    repeat (4) r = r * (16'd2 - m0 * r);
    return -r;
  endfunction

  function automatic int exp_lat(input int l);
    return 2 * l * l + 4 * l + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] en, input int a, input logic [15:0] d);
    wr_ena  = en;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_ena  = '0;
  endtask

  task automatic load_ops(input logic [63:0] x, input logic [63:0] y, input logic [63:0] m,
                          input int l);
    for (int w = 0; w < l; w++) begin
      write_word(3'b001, w, x[w*16 +: 16]);
      write_word(3'b010, w, y[w*16 +: 16]);
      write_word(3'b100, w, m[w*16 +: 16]);
    end
  endtask

  task automatic start_task(input int l, input logic [15:0] m1v);
    len      = LW'(l);
    m1       = m1v;
    task_req = 1'b1;
    tick();
    task_req = 1'b0;
    check_eq("grant", 64'(task_grant), 64'd1);
    check_eq("busy_at_grant", 64'(busy), 64'd1);
    check_eq("no_err_at_grant", 64'(task_err), 64'd0);
  endtask

  task automatic wait_end(input int l, input int already);
    int  cyc;
    bit  seen;
    cyc  = already;
    seen = 1'b0;
    while (cyc < 400 && !seen) begin
      tick();
      cyc++;
      if (task_end) seen = 1'b1;
    end
    check_eq("latency", 64'(cyc), 64'(exp_lat(l)));
  endtask

  task automatic read_res(input int l, output logic [63:0] r);
    r = '0;
    for (int w = 0; w < l; w++) begin
      rd_addr = AW'(w);
      tick();
      r[w*16 +: 16] = rd_data;
    end
  endtask

  task automatic run_case(input string tag, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] m, input int l);
    logic [63:0] r;
    load_ops(x, y, m, l);
    start_task(l, neg_inv(m[15:0]));
    wait_end(l, 0);
    read_res(l, r);
    check_eq(tag, r, mont_ref(x, y, m, l));
  endtask

  task automatic rand_ops(input int l, output logic [63:0] x, output logic [63:0] y,
                          output logic [63:0] m);
    logic [63:0] mask;
    mask = (l == 4) ? '1 : ((64'd1 << (16 * l)) - 64'd1);
    m    = ({$urandom, $urandom} & mask) | 64'd1;
    x    = {$urandom, $urandom} % m;
    y    = {$urandom, $urandom} % m;
  endtask

  task automatic bad_len(input int l);
    len      = LW'(l);
    task_req = 1'b1;
    tick();
    task_req = 1'b0;
    check_eq("err_pulse", 64'(task_err), 64'd1);
    check_eq("err_no_grant", 64'(task_grant), 64'd0);
    check_eq("err_busy", 64'(busy), 64'd0);
    tick();
    check_eq("err_one_cycle", 64'(task_err), 64'd0);
    check_eq("err_busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] x, y, m, r, x2, y2;
    int l;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_grant", 64'(task_grant), 64'd0);
    check_eq("rst_err", 64'(task_err), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_end", 64'(task_end), 64'd0);
    check_eq("rst_rd_data", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_case("len1_small", 64'h2, 64'h2, 64'h3, 1);
    run_case("len2_word1", 64'h1_0000, 64'h1_0000, 64'hFFFF_FFFF, 2);
    run_case("len2_final_sub", 64'hFFFF_FFFE, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 2);

    // Illegal lengths, then a normal task.
    bad_len(0);
    bad_len(5);
    run_case("after_err", 64'h2, 64'h2, 64'h3, 1);

    // Reset during LOOP_B of a len=4 task.
    rand_ops(4, x, y, m);
    load_ops(x, y, m, 4);
    start_task(4, neg_inv(m[15:0]));
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_end", 64'(task_end), 64'd0);
    check_eq("midrst_grant", 64'(task_grant), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("midrst_idle_end", 64'(task_end), 64'd0);
    run_case("after_midrst", 64'h2, 64'h2, 64'h3, 1);

    // x write while busy is ignored, both for this task and the next one.
    rand_ops(2, x, y, m);
    load_ops(x, y, m, 2);
    start_task(2, neg_inv(m[15:0]));
    x2 = ~x;
    write_word(3'b001, 0, x2[15:0]);
    wait_end(2, 1);
    read_res(2, r);
    check_eq("busy_write_res", r, mont_ref(x, y, m, 2));
    y2 = {$urandom, $urandom} % m;
    for (int w = 0; w < 2; w++) write_word(3'b010, w, y2[w*16 +: 16]);
    start_task(2, neg_inv(m[15:0]));
    wait_end(2, 0);
    read_res(2, r);
    check_eq("busy_write_xram", r, mont_ref(x, y2, m, 2));

    // Randomized tasks.
    for (int n = 0; n < 24; n++) begin
      l = int'($urandom_range(1, N));
      rand_ops(l, x, y, m);
      run_case("random", x, y, m, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
